// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with private HI/LO registers for the MIPS execute stage.
// Optional multiply-accumulate (MADD/MADDU) enabled by defining MD_UNIT_MADD_EN.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        read_sel,
  output logic        busy,
  output logic [31:0] out
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MD_UNIT_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MADDU = 3'b111;
`endif

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d;

  // Arithmetic on the latched operands only
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, dvsr_s, dvsr_u;
  logic [31:0] q_mag, r_mag, quo_s, rem_s, quo_u, rem_u;

  always_comb begin
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    a_mag  = a_q[31] ? 32'(-a_q) : a_q;
    b_mag  = b_q[31] ? 32'(-b_q) : b_q;
    // Divisor forced to 1 on zero so the dividers never see /0; result is discarded anyway
    dvsr_s = (b_q == 32'd0) ? 32'd1 : b_mag;
    dvsr_u = (b_q == 32'd0) ? 32'd1 : b_q;
    q_mag  = a_mag / dvsr_s;
    r_mag  = a_mag % dvsr_s;
    quo_s  = (a_q[31] ^ b_q[31]) ? 32'(-q_mag) : q_mag;
    rem_s  = a_q[31] ? 32'(-r_mag) : r_mag;
    quo_u  = a_q / dvsr_u;
    rem_u  = a_q % dvsr_u;
  end

`ifdef MD_UNIT_MADD_EN
  logic [63:0] acc;
  always_comb acc = {hi_q, lo_q} + (op_q[0] ? prod_u : prod_s);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU
`ifdef MD_UNIT_MADD_EN
            , OP_MADD, OP_MADDU
`endif
            : begin
              op_d    = op;
              a_d     = A;
              b_d     = B;
              cnt_d   = CNT_W'(MULT_CYCLES - 1);
              busy_d  = 1'b1;
              state_d = RUN;
            end
            OP_DIV, OP_DIVU: begin
              op_d    = op;
              a_d     = A;
              b_d     = B;
              cnt_d   = CNT_W'(DIV_CYCLES - 1);
              busy_d  = 1'b1;
              state_d = RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV: begin
              if (b_q != 32'd0) begin
                lo_d = quo_s;
                hi_d = rem_s;
              end
            end
            OP_DIVU: begin
              if (b_q != 32'd0) begin
                lo_d = quo_u;
                hi_d = rem_u;
              end
            end
`ifdef MD_UNIT_MADD_EN
            OP_MADD, OP_MADDU: {hi_d, lo_d} = acc;
`endif
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign out  = read_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Randomized self-checking bench for md_unit against an arithmetic HI/LO reference model.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        read_sel;
  logic        busy;
  logic [31:0] out;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_hi, m_lo;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .read_sel(read_sel), .busy(busy), .out(out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic int exp_cycles(input logic [2:0] o);
    case (o)
      3'd0, 3'd1: return 5;
      3'd2, 3'd3: return 10;
`ifdef MD_UNIT_MADD_EN
      3'd6, 3'd7: return 5;
`endif
      default:    return 0;
    endcase
  endfunction

  // Reference: what HI/LO become after op completes
  task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          ps;
    longint unsigned pu, acc;
    int              sa, sb;
    ps = longint'($signed(a)) * longint'($signed(b));
    pu = {32'd0, a} * {32'd0, b};
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      3'd0: {m_hi, m_lo} = ps;
      3'd1: {m_hi, m_lo} = pu;
      3'd2: if (b != 0) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000;
          m_hi = 32'h0;
        end else begin
          m_lo = sa / sb;
          m_hi = sa % sb;
        end
      end
      3'd3: if (b != 0) begin
        m_lo = a / b;
        m_hi = a % b;
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
`ifdef MD_UNIT_MADD_EN
      3'd6: begin acc = {m_hi, m_lo} + ps; {m_hi, m_lo} = acc; end
      3'd7: begin acc = {m_hi, m_lo} + pu; {m_hi, m_lo} = acc; end
`endif
      default: ;
    endcase
  endtask

  task automatic check_regs(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    read_sel = 1'b0;
    #1 chk({tag, ".lo"}, out, lo);
    read_sel = 1'b1;
    #1 chk({tag, ".hi"}, out, hi);
  endtask

  // Issue one op at a negedge, follow busy to completion, compare against the model
  task automatic issue(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int n;
    int ec;
    ec = exp_cycles(o);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
    A     = $urandom;
    B     = $urandom;
    if (ec > 0) check_regs({tag, ".pre"}, m_hi, m_lo);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({tag, ".busy_cyc"}, 32'(n), 32'(ec));
    model_op(o, a, b);
    check_regs(tag, m_hi, m_lo);
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    start    = 1'b0;
    op       = 3'd0;
    A        = 32'd0;
    B        = 32'd0;
    read_sel = 1'b0;
    m_hi     = 32'd0;
    m_lo     = 32'd0;
    @(negedge clk);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    check_regs("rst", 32'd0, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue("mult", 3'd0, 32'hFFFF_FFFE, 32'd3);
    check_regs("mult.k", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    issue("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_regs("multu.k", 32'hFFFF_FFFE, 32'h0000_0001);
    issue("div", 3'd2, 32'hFFFF_FFF9, 32'd2);
    check_regs("div.k", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue("divu", 3'd3, 32'hFFFF_FFF9, 32'd2);
    check_regs("divu.k", 32'h0000_0001, 32'h7FFF_FFFC);
    issue("mthi", 3'd4, 32'h1234_5678, 32'd0);
    issue("mtlo", 3'd5, 32'h9ABC_DEF0, 32'd0);
    issue("div0", 3'd2, 32'h0000_1234, 32'd0);
    check_regs("div0.k", 32'h1234_5678, 32'h9ABC_DEF0);
    issue("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check_regs("divovf.k", 32'h0000_0000, 32'h8000_0000);

    // Start while busy and operand changes mid-run must not disturb the result
    start = 1'b1; op = 3'd2; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 3'd5; A = 32'h55;
    @(negedge clk);
    start = 1'b0; A = 32'hDEAD_BEEF; B = 32'd0;
    n = 3;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("ign.busy_cyc", 32'(n - 1), 32'd10);
    model_op(3'd2, 32'd100, 32'd7);
    check_regs("ign", 32'd2, 32'd14);

    // Reset in mid-operation discards the result
    start = 1'b1; op = 3'd0; A = 32'h7; B = 32'h9;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1 chk("midrst.busy", {31'd0, busy}, 32'd0);
    start = 1'b1; op = 3'd3; A = 32'd1000; B = 32'd3;
    check_regs("midrst", 32'd0, 32'd0);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (12) @(negedge clk);
    chk("postrst.busy", {31'd0, busy}, 32'd0);
    check_regs("postrst", 32'd0, 32'd0);

    issue("m_mthi", 3'd4, 32'd0, 32'd0);
    issue("m_mtlo", 3'd5, 32'hFFFF_FFFF, 32'd0);
    issue("maddu", 3'd7, 32'd1, 32'd1);
`ifdef MD_UNIT_MADD_EN
    check_regs("maddu.k", 32'd1, 32'd0);
`else
    check_regs("maddu.k", 32'd0, 32'hFFFF_FFFF);
`endif

    for (int i = 0; i < 60; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 9));
        3: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
        default: ;
      endcase
      issue("rand", ro, ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%08h exp=%08h", 32'd0, 32'd1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with its own HI/LO registers for the MIPS datapath.
- Sits in the execute stage beside the ALU.
- Its `out` port feeds the 32-bit write-back data selector, which chooses between the ALU result, memory data, PC+8 and this unit.
- Also provides the `busy` signal the hazard logic uses to stall mult/div/mfhi/mflo/mthi/mtlo.

Parameters:
- MULT_CYCLES, 5, edges from mult/multu acceptance to HI/LO update (≥1).
- DIV_CYCLES, 10, edges from div/divu acceptance to HI/LO update (≥1).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous active-high reset.
- start  input  1  launch the operation on `op` this cycle.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MADDU.
- A  input  32  rs operand.
- B  input  32  rt operand.
- read_sel  input  1  0 selects LO, 1 selects HI on `out`.
- busy  output  1  operation in flight.
- out  output  32  selected HI or LO (combinational from registers).

Behaviour:
- Reset is asynchronous and active-high. It forces HI=0, LO=0, busy=0, counter=0 and state IDLE immediately, including mid-operation; the in-flight result is discarded.
- FSM has two states, IDLE and RUN.
- IDLE, on start & op∈{MULT,MULTU,DIV,DIVU}:
  - latch A, B and op;
  - load counter = MULT_CYCLES-1 or DIV_CYCLES-1;
  - go to RUN;
  - busy=1 from the next cycle.
- IDLE, on start & op=MTHI: HI<=A at this edge; busy stays 0. op=MTLO writes LO the same way.
- RUN: counter decrements each edge. On the edge where counter==0:
  - HI/LO are written with the result;
  - busy<=0;
  - go to IDLE.
  - busy is therefore high for exactly N cycles.
- start while busy=1 is ignored; the hazard unit guarantees this cannot happen, and the bench checks that the registers are unaffected.
- `out` reflects pre-update HI/LO until the completion edge. Reading is not blocked by the unit; stalling mfhi/mflo is the hazard unit's job, on start|busy.
- MULT: {HI,LO} = signed A × signed B, 64-bit.
- MULTU: {HI,LO} = unsigned A × unsigned B.
- DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient/remainder.
- Divide by zero (B==0): the op still occupies DIV_CYCLES, and HI and LO keep their prior values.
- Computation uses the latched operands only; A/B changing during RUN has no effect.
- op values 110/111 without the optional feature are treated as no-op: no busy, no register write.

Optional Feature:
- Macro MD_UNIT_MADD_EN.
- When defined:
  - MADD: {HI,LO} <= {HI,LO} + signed A×B.
  - MADDU: {HI,LO} <= {HI,LO} + unsigned A×B.
  - Both take MULT_CYCLES, and accumulation wraps modulo 2^64.
  - The {HI,LO} summand is the value at the completion edge; an MTHI/MTLO cannot intervene because it is ignored while busy.
- When undefined: op 110/111 is a no-op as above, and no adder logic is synthesized.

Test Plan:
- Reset, then start MULT A=0xFFFFFFFE (−2), B=3:
  - busy=1 for exactly 5 cycles;
  - afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - Before completion, out (read_sel=0) still shows 0.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles.
- Signed division checks:
  - DIV A=0xFFFFFFF9 (−7), B=2 → busy for 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU on the same operands → LO=0x7FFFFFFC, HI=1.
- Divide-by-zero and overflow edge cases:
  - MTHI 0x12345678, MTLO 0x9ABCDEF0, then DIV B=0 → after 10 cycles HI/LO unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Start DIV, then pulse start with MTLO A=0x55 and change A/B on cycle 3:
  - both are ignored, and the result matches the latched operands.
  - Assert reset on cycle 6: busy=0, HI=LO=0 immediately, with no later write.
- With MD_UNIT_MADD_EN defined: MTHI 0, MTLO 0xFFFFFFFF, MADDU A=1, B=1 → HI=1, LO=0. Without the macro: same stimulus leaves HI=0, LO=0xFFFFFFFF, busy never asserted.
